// File: rtl/mem_arbiter.sv
// mem_arbiter: two-core instruction/data arbiter in front of a single RAM port.
// Data requests beat instruction requests; within a class a round-robin
// pointer picks the core. Data grants may hold the RAM for a 2-word block.
module mem_arbiter #(
    parameter int unsigned BURST_HOLD = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [1:0]        iREN,
    input  logic [1:0][31:0]  iaddr,
    input  logic [1:0]        dREN,
    input  logic [1:0]        dWEN,
    input  logic [1:0][31:0]  daddr,
    input  logic [1:0][31:0]  dstore,
    output logic [1:0]        iwait,
    output logic [1:0]        dwait,
    output logic [1:0][31:0]  iload,
    output logic [1:0][31:0]  dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [31:0]       ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  logic [1:0]        ramstate
);
    localparam logic [0:0] IDLE       = 1'b0;
    localparam logic [0:0] SERVE      = 1'b1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic       BURST_EN   = (BURST_HOLD != 0);

    logic [0:0] r_state;
    logic       r_gnt_core;
    logic       r_gnt_data;
    logic       r_rr_ptr;
    logic       r_hold;

    logic [1:0] w_dreq;
    logic       w_pick_d;
    logic       w_pick_i;
    logic       w_live;
    logic       w_serving;
    logic       w_done;
    logic       w_is_write;
    logic       w_burst_next;

    // Arbitration choice and status of the currently granted requester
    always_comb begin
        w_dreq       = dREN | dWEN;
        w_pick_d     = w_dreq[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
        w_pick_i     = iREN[r_rr_ptr]   ? r_rr_ptr : ~r_rr_ptr;
        w_live       = r_gnt_data ? w_dreq[r_gnt_core] : iREN[r_gnt_core];
        w_serving    = (r_state == SERVE) && w_live;
        w_done       = w_serving && (ramstate == RAM_ACCESS);
        w_is_write   = r_gnt_data && dWEN[r_gnt_core];
        w_burst_next = BURST_EN && r_gnt_data && !r_hold && !daddr[r_gnt_core][2];
    end

    // RAM strobes follow the granted requester; stall/load outputs per core
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        if (w_serving) begin
            ramWEN   = w_is_write;
            ramREN   = !w_is_write;
            ramaddr  = r_gnt_data ? daddr[r_gnt_core] : iaddr[r_gnt_core];
            ramstore = r_gnt_data ? dstore[r_gnt_core] : '0;
        end
        if (w_done) begin
            if (r_gnt_data) begin
                dwait[r_gnt_core] = 1'b0;
                if (!w_is_write) begin
                    dload[r_gnt_core] = ramload;
                end
            end else begin
                iwait[r_gnt_core] = 1'b0;
                iload[r_gnt_core] = ramload;
            end
        end
    end

    // Grant latching, burst hold and round-robin pointer update
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_gnt_core <= 1'b0;
            r_gnt_data <= 1'b0;
            r_rr_ptr   <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_hold <= 1'b0;
                    if (|w_dreq) begin
                        r_gnt_data <= 1'b1;
                        r_gnt_core <= w_pick_d;
                        r_state    <= SERVE;
                    end else if (|iREN) begin
                        r_gnt_data <= 1'b0;
                        r_gnt_core <= w_pick_i;
                        r_state    <= SERVE;
                    end
                end
                SERVE: begin
                    if (!w_live) begin
                        // abandoned request: no completion, pointer untouched
                        r_state <= IDLE;
                        r_hold  <= 1'b0;
                    end else if (w_done) begin
                        if (w_burst_next) begin
                            r_hold <= 1'b1;
                        end else begin
                            r_state  <= IDLE;
                            r_hold   <= 1'b0;
                            r_rr_ptr <= ~r_gnt_core;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: per-cycle vector table plus completion scoreboard,
// with hand-written sequences for reset abort and non-burst alternation.
module tb_mem_arbiter;
    logic              CLK;
    logic              nRST;
    logic [1:0]        iREN, dREN, dWEN;
    logic [1:0][31:0]  iaddr, daddr, dstore;
    logic [1:0]        iwait, dwait;
    logic [1:0][31:0]  iload, dload;
    logic              ramREN, ramWEN;
    logic [31:0]       ramaddr, ramstore, ramload;
    logic [1:0]        ramstate;

    logic [1:0]        d0_iwait, d0_dwait;
    logic [1:0][31:0]  d0_iload, d0_dload;
    logic              d0_ramREN, d0_ramWEN;
    logic [31:0]       d0_ramaddr, d0_ramstore;

    mem_arbiter #(.BURST_HOLD(1)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    mem_arbiter #(.BURST_HOLD(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(d0_iwait), .dwait(d0_dwait), .iload(d0_iload),
        .dload(d0_dload), .ramREN(d0_ramREN), .ramWEN(d0_ramWEN), .ramaddr(d0_ramaddr),
        .ramstore(d0_ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        d;
        logic        c;
        logic [31:0] ld;
    } sb_t;

    typedef struct {
        logic [1:0]  ir, dr, dw;
        logic [31:0] a0, a1, st;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        er, ew;
        logic [31:0] ea, es;
        logic [3:0]  wt;      // {dwait[1], dwait[0], iwait[1], iwait[0]}
        logic        pv;
        sb_t         pe;
        logic        rrv, rr;
    } vec_t;

    int  n_checks = 0;
    int  n_fail   = 0;
    sb_t sb[$];
    vec_t vecs[$];

    function automatic vec_t V(input logic [1:0] ir, input logic [1:0] dr, input logic [1:0] dw,
                               input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] st,
                               input logic [1:0] rs, input logic [31:0] rl,
                               input logic er, input logic ew, input logic [31:0] ea,
                               input logic [31:0] es, input logic [3:0] wt);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.a0 = a0; v.a1 = a1; v.st = st;
        v.rs = rs; v.rl = rl; v.er = er; v.ew = ew; v.ea = ea; v.es = es; v.wt = wt;
        v.pv = 1'b0; v.pe.d = 1'b0; v.pe.c = 1'b0; v.pe.ld = '0;
        v.rrv = 1'b0; v.rr = 1'b0;
        return v;
    endfunction

    function automatic vec_t P(input vec_t vi, input logic d, input logic c, input logic [31:0] ld);
        vec_t v = vi;
        v.pv = 1'b1; v.pe.d = d; v.pe.c = c; v.pe.ld = ld;
        return v;
    endfunction

    function automatic vec_t R(input vec_t vi, input logic rr);
        vec_t v = vi;
        v.rrv = 1'b1; v.rr = rr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = 2'd0; ramload = '0;
    endtask

    // Pops the expected completion whenever a wait drops, checks idle loads
    task automatic sb_monitor(input int idx);
        logic bad;
        bad = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (!iwait[c] || !dwait[c]) begin
                if (sb.size() == 0) begin
                    chk($sformatf("r%0d_sb_unexpected_completion", idx), 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk($sformatf("r%0d_sb_who", idx), {30'd0, !iwait[c] ? 1'b0 : 1'b1, c[0]},
                        {30'd0, e.d, e.c});
                    chk($sformatf("r%0d_sb_load", idx), !iwait[c] ? iload[c] : dload[c], e.ld);
                end
            end
            if (iwait[c] && iload[c] != '0) bad = 1'b1;
            if (dwait[c] && dload[c] != '0) bad = 1'b1;
        end
        chk($sformatf("r%0d_idle_loads_zero", idx), {31'd0, bad}, 32'd0);
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge CLK);
        iREN = v.ir; dREN = v.dr; dWEN = v.dw;
        iaddr[0] = v.a0; daddr[0] = v.a0; iaddr[1] = v.a1; daddr[1] = v.a1;
        dstore[0] = v.st; dstore[1] = v.st;
        ramstate = v.rs; ramload = v.rl;
        if (v.pv) sb.push_back(v.pe);
        #1;
        chk($sformatf("r%0d_ramREN", idx), {31'd0, ramREN}, {31'd0, v.er});
        chk($sformatf("r%0d_ramWEN", idx), {31'd0, ramWEN}, {31'd0, v.ew});
        chk($sformatf("r%0d_ramaddr", idx), ramaddr, v.ea);
        chk($sformatf("r%0d_ramstore", idx), ramstore, v.es);
        chk($sformatf("r%0d_waits", idx), {28'd0, dwait, iwait}, {28'd0, v.wt});
        if (v.rrv) chk($sformatf("r%0d_rr_ptr", idx), {31'd0, dut.r_rr_ptr}, {31'd0, v.rr});
        sb_monitor(idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp0 [8];
        logic [1:0] exp1 [8];
        exp0 = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
        exp1 = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b10};

        // A: single instruction fetch, 2-cycle latency
        vecs.push_back(P(V(2'b01,2'b00,2'b00, 32'h40,0,0, 2'd0,0, 0,0,0,0, 4'hF), 1'b0,1'b0,32'hDEADBEEF));
        vecs.push_back(V(2'b01,2'b00,2'b00, 32'h40,0,0, 2'd2,32'hDEADBEEF, 1,0,32'h40,0, 4'b1110));
        vecs.push_back(R(V(2'b00,2'b00,2'b00, 0,0,0, 2'd0,0, 0,0,0,0, 4'hF), 1'b1));
        // B: data beats instruction; core1 drops during its burst hold
        vecs.push_back(P(V(2'b01,2'b00,2'b10, 32'h80,32'h3100,5, 2'd0,0, 0,0,0,0, 4'hF), 1'b1,1'b1,32'h0));
        vecs.push_back(P(V(2'b01,2'b00,2'b10, 32'h80,32'h3100,5, 2'd2,32'h9999, 0,1,32'h3100,5, 4'b0111), 1'b0,1'b0,32'h1111));
        vecs.push_back(R(V(2'b01,2'b00,2'b00, 32'h80,32'h3100,5, 2'd0,0, 0,0,0,0, 4'hF), 1'b1));
        vecs.push_back(R(V(2'b01,2'b00,2'b00, 32'h80,0,0, 2'd0,0, 0,0,0,0, 4'hF), 1'b1));
        vecs.push_back(V(2'b01,2'b00,2'b00, 32'h80,0,0, 2'd2,32'h1111, 1,0,32'h80,0, 4'b1110));
        vecs.push_back(R(V(2'b00,2'b00,2'b00, 0,0,0, 2'd0,0, 0,0,0,0, 4'hF), 1'b1));
        // C: core1 two-word write burst completes before pending core0 read
        vecs.push_back(P(V(2'b00,2'b01,2'b10, 32'h504,32'h200,32'hA, 2'd0,0, 0,0,0,0, 4'hF), 1'b1,1'b1,32'h0));
        vecs.push_back(P(V(2'b00,2'b01,2'b10, 32'h504,32'h200,32'hA, 2'd1,0, 0,1,32'h200,32'hA, 4'hF), 1'b1,1'b1,32'h0));
        vecs.push_back(P(V(2'b00,2'b01,2'b10, 32'h504,32'h200,32'hA, 2'd2,0, 0,1,32'h200,32'hA, 4'b0111), 1'b1,1'b0,32'h7777));
        vecs.push_back(R(V(2'b00,2'b01,2'b10, 32'h504,32'h204,32'hB, 2'd2,0, 0,1,32'h204,32'hB, 4'b0111), 1'b1));
        vecs.push_back(R(V(2'b00,2'b01,2'b10, 32'h504,32'h208,32'hC, 2'd0,0, 0,0,0,0, 4'hF), 1'b0));
        vecs.push_back(V(2'b00,2'b01,2'b10, 32'h504,32'h208,32'hC, 2'd2,32'h7777, 1,0,32'h504,32'hC, 4'b1011));
        vecs.push_back(R(V(2'b00,2'b00,2'b00, 0,0,0, 2'd0,0, 0,0,0,0, 4'hF), 1'b1));
        // D: ERROR retried three cycles, then one completion
        vecs.push_back(P(V(2'b10,2'b00,2'b00, 0,32'h600,0, 2'd0,0, 0,0,0,0, 4'hF), 1'b0,1'b1,32'hCAFEF00D));
        for (int k = 0; k < 3; k++)
            vecs.push_back(V(2'b10,2'b00,2'b00, 0,32'h600,0, 2'd3,32'h5555, 1,0,32'h600,0, 4'hF));
        vecs.push_back(V(2'b10,2'b00,2'b00, 0,32'h600,0, 2'd2,32'hCAFEF00D, 1,0,32'h600,0, 4'b1101));
        vecs.push_back(R(V(2'b00,2'b00,2'b00, 0,0,0, 2'd0,0, 0,0,0,0, 4'hF), 1'b0));
        // E: request arriving with a completion waits one idle bubble
        vecs.push_back(P(V(2'b01,2'b00,2'b00, 32'h10,0,0, 2'd0,0, 0,0,0,0, 4'hF), 1'b0,1'b0,32'h12345678));
        vecs.push_back(P(V(2'b11,2'b00,2'b00, 32'h10,32'h20,0, 2'd2,32'h12345678, 1,0,32'h10,0, 4'b1110), 1'b0,1'b1,32'h87654321));
        vecs.push_back(R(V(2'b10,2'b00,2'b00, 0,32'h20,0, 2'd2,32'hFFFF0000, 0,0,0,0, 4'hF), 1'b1));
        vecs.push_back(V(2'b10,2'b00,2'b00, 0,32'h20,0, 2'd2,32'h87654321, 1,0,32'h20,0, 4'b1101));
        vecs.push_back(R(V(2'b00,2'b00,2'b00, 0,0,0, 2'd0,0, 0,0,0,0, 4'hF), 1'b0));

        // Reset state, with requests and ACCESS present to show they are ignored
        zero_inputs();
        nRST = 1'b0;
        iREN = 2'b11; dREN = 2'b11; ramstate = 2'd2; ramload = 32'hFFFFFFFF;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        chk("reset_waits", {28'd0, dwait, iwait}, 32'hF);
        chk("reset_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("reset_ramaddr", ramaddr, 32'd0);
        chk("reset_ramstore", ramstore, 32'd0);
        chk("reset_loads", {31'd0, (iload != '0) || (dload != '0)}, 32'd0);
        chk("reset_rr_ptr", {31'd0, dut.r_rr_ptr}, 32'd0);
        @(negedge CLK);
        zero_inputs();
        nRST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Reset asserted mid-SERVE aborts without a completion
        @(negedge CLK);
        zero_inputs(); dREN = 2'b01; iaddr[0] = 32'h700; daddr[0] = 32'h700;
        #1 chk("abort_idle_ren", {31'd0, ramREN}, 32'd0);
        @(negedge CLK);
        ramstate = 2'd1;
        #1;
        chk("abort_serve_ren", {31'd0, ramREN}, 32'd1);
        chk("abort_serve_addr", ramaddr, 32'h700);
        #2 nRST = 1'b0; ramstate = 2'd2; ramload = 32'h1234;
        #1;
        chk("abort_strobes_now", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("abort_addr_now", ramaddr, 32'd0);
        chk("abort_waits_now", {28'd0, dwait, iwait}, 32'hF);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK); #1;
            chk($sformatf("abort_hold%0d_waits", k), {28'd0, dwait, iwait}, 32'hF);
            chk($sformatf("abort_hold%0d_dload", k), dload[0], 32'd0);
        end
        @(negedge CLK);
        zero_inputs();
        nRST = 1'b1;
        #1;
        chk("abort_state_idle", {31'd0, dut.r_state}, 32'd0);
        chk("abort_rr_ptr", {31'd0, dut.r_rr_ptr}, 32'd0);
        chk("abort_strobes_after", {30'd0, ramREN, ramWEN}, 32'd0);

        // Persistent reads from both cores: alternation without hold, pairs with hold
        for (int k = 0; k < 8; k++) begin
            logic [31:0] rl;
            @(negedge CLK);
            rl = 32'hA000_0000 + 32'(k);
            dREN = 2'b11; iaddr = '0; dstore = '0;
            daddr[0] = 32'h1000; daddr[1] = 32'h2000;
            ramstate = 2'd2; ramload = rl;
            #1;
            chk($sformatf("alt%0d_nohold_dwait", k), {30'd0, d0_dwait}, {30'd0, exp0[k]});
            chk($sformatf("alt%0d_hold_dwait", k), {30'd0, dwait}, {30'd0, exp1[k]});
            chk($sformatf("alt%0d_nohold_ren", k), {31'd0, d0_ramREN}, {31'd0, exp0[k] != 2'b11});
            chk($sformatf("alt%0d_nohold_misc", k), {28'd0, d0_iwait, d0_ramWEN, d0_iload != '0},
                {28'd0, 2'b11, 1'b0, 1'b0});
            chk($sformatf("alt%0d_nohold_store", k), d0_ramstore, 32'd0);
            if (k % 2 == 1) begin
                chk($sformatf("alt%0d_nohold_addr", k), d0_ramaddr,
                    (exp0[k] == 2'b10) ? 32'h1000 : 32'h2000);
                chk($sformatf("alt%0d_nohold_load", k),
                    (exp0[k] == 2'b10) ? d0_dload[0] : d0_dload[1], rl);
            end
        end
        @(negedge CLK);
        zero_inputs();
        #1 chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_HOLD, default 1, meaning: 1 keeps the grant on a data requester across the second word of a 2-word block (addr+4).
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 iREN  input  [1:0]  instruction read request, per core c=0,1.
REQ-005 iaddr  input  [1:0]x32  instruction word address, per core.
REQ-006 dREN, dWEN  input  [1:0] each  data read/write request, per core; both high on one core is treated as write.
REQ-007 daddr, dstore  input  [1:0]x32 each  data address / write data, per core.
REQ-008 iwait, dwait  output  [1:0] each  per-core stall; 0 for exactly one cycle when that request completes.
REQ-009 iload, dload  output  [1:0]x32 each  read data, valid only in the completion cycle, else 0.
REQ-010 ramREN, ramWEN  output  1 each  RAM strobes.
REQ-011 ramaddr, ramstore  output  32 each  RAM address / write data.
REQ-012 ramload  input  32  RAM read data.
REQ-013 ramstate  input  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-014 The block SHALL have FSM states IDLE and SERVE, plus registers gnt_core (1b), gnt_data (1b), rr_ptr (1b), hold (1b).
REQ-015 In IDLE, the request set SHALL be evaluated with priority: data over instruction; within a class, core rr_ptr first, then core ~rr_ptr.
REQ-016 On any valid request in IDLE, the block SHALL latch gnt_core/gnt_data and go to SERVE next cycle; with no request, it SHALL remain in IDLE with the RAM strobes low.
REQ-017 In SERVE, ramaddr/ramstore/ramREN/ramWEN SHALL follow the granted requester's live inputs combinationally.
REQ-018 In SERVE, when ramstate==ACCESS, the granted requester's wait SHALL be 0 and its load SHALL equal ramload (reads) in that cycle.
REQ-019 After the ACCESS cycle, the FSM SHALL return to IDLE and set rr_ptr=~gnt_core, unless REQ-020 applies.
REQ-020 With BURST_HOLD=1, a data grant whose completed address has bit2==0 SHALL set hold and stay in SERVE for one more word from the same core; hold clears after that word or if the core drops its request.
REQ-021 ramstate BUSY/FREE/ERROR in SERVE SHALL keep all waits 1 and the request asserted (ERROR is retried indefinitely).
REQ-022 If the granted requester deasserts its request in SERVE, the block SHALL drop RAM strobes that cycle, return to IDLE, leave rr_ptr unchanged, and signal no completion.
REQ-023 Non-granted requesters SHALL see wait=1 and load=0 in every cycle.
REQ-024 A new request arriving in the same cycle as a completion SHALL NOT be granted before the following IDLE cycle (one idle bubble, no hold).
REQ-025 Minimum latency SHALL be 2 cycles from request assertion to wait=0 (IDLE grant + SERVE with ACCESS).

Reset
REQ-026 On nRST low, the block SHALL asynchronously enter IDLE with rr_ptr=0, gnt_core=0, gnt_data=0, hold=0.
REQ-027 During and right after reset, all waits SHALL be 1, all loads 0, and ramREN/ramWEN/ramaddr/ramstore 0.
REQ-028 Reset asserted mid-SERVE SHALL abort the transfer without a completion pulse.

Verification
REQ-029 Core0 iREN, iaddr=0x40, ramstate ACCESS on the 2nd cycle with ramload=0xDEADBEEF -> iwait[0]=0, iload[0]=0xDEADBEEF for one cycle, rr_ptr=1.
REQ-030 Core0 iREN and core1 dWEN (daddr=0x3100, dstore=0x5) together -> core1 data served first with ramWEN=1, ramaddr=0x3100; core0 served next.
REQ-031 Both cores dREN persistently, BURST_HOLD=0 -> grants alternate 0,1,0,1.
REQ-032 Core1 dWEN at 0x200 then 0x204, BURST_HOLD=1, core0 dREN pending -> both core1 words complete before core0 is granted.
REQ-033 ramstate ERROR for 3 cycles then ACCESS -> wait stays 1 for 3 cycles, then a single completion.
REQ-034 nRST low during SERVE -> strobes 0 immediately, no wait=0 pulse, IDLE with rr_ptr=0 after release.
